// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
// Shared WS2812 timing constants, the receiver state encoding and a small
// saturating-counter helper. The tick constants assume a 27 MHz clock and are
// also used by the WS2812 transmitter, so both sides agree on bit timing.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package ws2812_pkg;

    // High time of a 0 bit, high time of a 1 bit, nominal low time, refresh gap
    localparam int T0H_TICKS  = 9;
    localparam int T1H_TICKS  = 19;
    localparam int TXL_TICKS  = 31;
    localparam int RFSH_TICKS = 1350;

    // A pulse at or above the midpoint of T0H and T1H decodes as a 1
    localparam int BIT_THRESH_TICKS = (T0H_TICKS + T1H_TICKS) / 2;

    localparam int CNT_W     = 11;
    localparam int WORD_BITS = 24;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } rx_state_e;

    // Increment that sticks at lim instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v < lim) ? (v + 11'd1) : lim;
    endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// ----------------------------------------------------------------------------
// ws2812_rx_if
// Bundles the serial line and the decoded outputs of the WS2812 receiver.
//   din       : serial line into the decoder (asynchronous to clk)
//   color     : last complete {G,R,B} word
//   valid     : one-cycle pulse when color updates
//   frame_end : one-cycle pulse on reset-gap detection
//   err       : one-cycle pulse on glitch, overlong high or partial word
//   dout      : retimed forward of din for the next node in the chain
// master drives the line and observes results; slave is the decoder.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface ws2812_rx_if;
    logic        din;
    logic [23:0] color;
    logic        valid;
    logic        frame_end;
    logic        err;
    logic        dout;

    modport master (
        output din,
        input  color, valid, frame_end, err, dout
    );

    modport slave (
        input  din,
        output color, valid, frame_end, err, dout
    );
endinterface

// File: rtl/ws2812_rx_sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for an asynchronous input followed by a history
// register and registered rise/fall strobes. Usable for buttons as well.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : asynchronous input
//   level_o    : synchronised level
//   rise_o     : one-cycle strobe after a synchronised 0->1 transition
//   fall_o     : one-cycle strobe after a synchronised 1->0 transition
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // Synchroniser chain, edge-detect history and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ws2812_rx.sv
// ----------------------------------------------------------------------------
// ws2812_rx
// WS2812 receive decoder. Measures each high pulse in clock ticks, decodes
// MSB-first 24-bit words and forwards the rest of the frame on dout, as an
// LED in a daisy chain would.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ws2812_rx_if.slave (din in; color/valid/frame_end/err/dout out)
// All outputs are registered.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module ws2812_rx #(
    parameter int CLK_FREQ         = 27000000,
    parameter int MIN_HIGH_TICKS   = 3,
    parameter int BIT_THRESH_TICKS = ws2812_pkg::BIT_THRESH_TICKS,
    parameter int MAX_HIGH_TICKS   = 40,
    parameter int RESET_TICKS      = ws2812_pkg::RFSH_TICKS
) (
    input  logic        clk,
    input  logic        rst_n,
    ws2812_rx_if.slave  bus
);
    import ws2812_pkg::*;

    // Thresholds must be ordered and fit the 11-bit counters
    if (CLK_FREQ <= 0 || MIN_HIGH_TICKS >= BIT_THRESH_TICKS ||
        BIT_THRESH_TICKS >= MAX_HIGH_TICKS || RESET_TICKS >= 2048) begin : g_param_check
        $error("ws2812_rx: inconsistent timing parameters");
    end

    localparam logic [CNT_W-1:0] MIN_L    = CNT_W'(MIN_HIGH_TICKS);
    localparam logic [CNT_W-1:0] THRESH_L = CNT_W'(BIT_THRESH_TICKS);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_HIGH_TICKS);
    localparam logic [CNT_W-1:0] RESET_L  = CNT_W'(RESET_TICKS);
    localparam logic [4:0]       LAST_BIT = 5'd23;
    localparam logic [4:0]       FULL_CNT = 5'd24;

    logic line_s;
    logic rise_s;
    logic fall_s;
    logic bit_s;

    rx_state_e        state_q,     state_d;
    logic [CNT_W-1:0] hcnt_q,      hcnt_d;
    logic [CNT_W-1:0] lcnt_q,      lcnt_d;
    logic [4:0]       bit_cnt_q,   bit_cnt_d;
    logic [22:0]      shreg_q,     shreg_d;    // first 23 bits; the 24th goes straight to color
    logic [23:0]      color_q,     color_d;
    logic             pass_q,      pass_d;
    logic             valid_q,     valid_d;
    logic             frame_end_q, frame_end_d;
    logic             err_q,       err_d;
    logic             dout_q,      dout_d;

    sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.din),
        .level_o (line_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    assign bit_s = (hcnt_q >= THRESH_L);

    // Next-state and output decode of the pulse-measuring state machine
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        lcnt_d      = lcnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        color_d     = color_q;
        pass_d      = pass_q;
        valid_d     = 1'b0;
        frame_end_d = 1'b0;
        err_d       = 1'b0;
        dout_d      = pass_q & line_s;

        case (state_q)
            SYNC: begin
                // Wait for a full reset gap before trusting any edge
                if (line_s) begin
                    lcnt_d = 11'd0;
                end else if (lcnt_q == RESET_L - 11'd1) begin
                    state_d   = LOW;
                    lcnt_d    = RESET_L;   // already saturated: no frame_end for this gap
                    bit_cnt_d = 5'd0;
                    shreg_d   = 23'd0;
                    pass_d    = 1'b0;
                end else begin
                    lcnt_d = lcnt_q + 11'd1;
                end
            end

            LOW: begin
                if (rise_s) begin
                    state_d = HIGH;
                    hcnt_d  = 11'd0;
                    lcnt_d  = 11'd0;
                end else if (lcnt_q == RESET_L - 11'd1) begin
                    lcnt_d      = RESET_L;
                    frame_end_d = 1'b1;
                    if (bit_cnt_q != 5'd0 && bit_cnt_q < FULL_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                    end
                    shreg_d   = 23'd0;
                    bit_cnt_d = 5'd0;
                    pass_d    = 1'b0;
                end else begin
                    lcnt_d = sat_inc(lcnt_q, RESET_L);
                end
            end

            HIGH: begin
                if (fall_s) begin
                    state_d = LOW;
                    lcnt_d  = 11'd0;
                    if (hcnt_q < MIN_L) begin
                        err_d = 1'b1;                       // glitch: bit dropped
                    end else if (bit_cnt_q == LAST_BIT) begin
                        color_d   = {shreg_q, bit_s};
                        valid_d   = 1'b1;
                        pass_d    = 1'b1;
                        bit_cnt_d = FULL_CNT;
                    end else if (bit_cnt_q < LAST_BIT) begin
                        shreg_d   = {shreg_q[21:0], bit_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q;              // downstream bits: dout only
                    end
                end else if (hcnt_q == MAX_L - 11'd1) begin
                    hcnt_d    = MAX_L;
                    err_d     = 1'b1;
                    state_d   = SYNC;
                    lcnt_d    = 11'd0;
                    bit_cnt_d = 5'd0;
                    shreg_d   = 23'd0;
                    pass_d    = 1'b0;
                end else begin
                    hcnt_d = sat_inc(hcnt_q, MAX_L);
                end
            end

            default: begin
                state_d = SYNC;
                lcnt_d  = 11'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            hcnt_q      <= 11'd0;
            lcnt_q      <= 11'd0;
            bit_cnt_q   <= 5'd0;
            shreg_q     <= 23'd0;
            color_q     <= 24'd0;
            pass_q      <= 1'b0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            err_q       <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            lcnt_q      <= lcnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            color_q     <= color_d;
            pass_q      <= pass_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            err_q       <= err_d;
            dout_q      <= dout_d;
        end
    end

    assign bus.color     = color_q;
    assign bus.valid     = valid_q;
    assign bus.frame_end = frame_end_q;
    assign bus.err       = err_q;
    assign bus.dout      = dout_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// ----------------------------------------------------------------------------
// tb_ws2812_rx
// Directed stimulus for ws2812_rx. Expected output events are queued as each
// sequence is issued; a monitor pops and compares whenever valid, err or
// frame_end is seen.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ws2812_rx;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic        frame_end;
        logic [23:0] color;
    } evt_t;

    logic clk;
    logic rst_n;

    int   checks = 0;
    int   passes = 0;
    evt_t exp_q[$];

    logic [3:0] din_hist  = 4'd0;
    logic       dout_prev = 1'b0;
    logic       dout_chk_en  = 1'b0;   // dout must equal din three samples back
    logic       dout_zero_en = 1'b0;   // dout must stay 0
    int         dout_bad   = 0;
    int         dout_rises = 0;

    ws2812_rx_if bus_if ();

    ws2812_rx #(
        .CLK_FREQ         (27000000),
        .MIN_HIGH_TICKS   (3),
        .BIT_THRESH_TICKS (14),
        .MAX_HIGH_TICKS   (40),
        .RESET_TICKS      (1350)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic v, input logic e, input logic f, input logic [23:0] c);
        evt_t ev;
        ev.valid = v; ev.err = e; ev.frame_end = f; ev.color = c;
        exp_q.push_back(ev);
    endtask

    // Drive din to v for n clocks; returns 1 ns after a rising edge
    task automatic hold(input logic v, input int n);
        bus_if.din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) begin hold(1'b1, 19); hold(1'b0, 35); end
        else   begin hold(1'b1, 9);  hold(1'b0, 31); end
    endtask

    task automatic send_range(input logic [23:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic monitor_loop();
        evt_t got;
        evt_t exp;
        forever begin
            @(negedge clk);
            din_hist = {din_hist[2:0], bus_if.din};
            if (dout_chk_en && (bus_if.dout !== din_hist[3])) dout_bad++;
            if (dout_zero_en && (bus_if.dout !== 1'b0)) dout_bad++;
            if (dout_chk_en && bus_if.dout && !dout_prev) dout_rises++;
            dout_prev = bus_if.dout;
            if (rst_n && (bus_if.valid || bus_if.err || bus_if.frame_end)) begin
                got.valid = bus_if.valid; got.err = bus_if.err;
                got.frame_end = bus_if.frame_end; got.color = bus_if.color;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: got v=%0b e=%0b f=%0b color=%h, expected none",
                             got.valid, got.err, got.frame_end, got.color);
                end else begin
                    exp = exp_q.pop_front();
                    if (got === exp) passes++;
                    else $display("FAIL event: got v=%0b e=%0b f=%0b color=%h, expected v=%0b e=%0b f=%0b color=%h",
                                  got.valid, got.err, got.frame_end, got.color,
                                  exp.valid, exp.err, exp.frame_end, exp.color);
                end
            end
        end
    endtask

    initial begin
        int bad0;
        int rise0;
        bus_if.din = 1'b0;
        rst_n = 1'b0;
        fork monitor_loop(); join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset_color",     {8'd0, bus_if.color}, 32'd0);
        check("reset_valid",     {31'd0, bus_if.valid}, 32'd0);
        check("reset_frame_end", {31'd0, bus_if.frame_end}, 32'd0);
        check("reset_err",       {31'd0, bus_if.err}, 32'd0);
        check("reset_dout",      {31'd0, bus_if.dout}, 32'd0);
        rst_n = 1'b1;

        // Single word after an initial reset gap; nothing is forwarded
        hold(1'b0, 1400);
        push(1'b1, 1'b0, 1'b0, 24'hB4B4B4);
        push(1'b0, 1'b0, 1'b1, 24'hB4B4B4);
        bad0 = dout_bad;
        dout_zero_en = 1'b1;
        send_range(24'hB4B4B4, 23, 0);
        hold(1'b0, 1400);
        dout_zero_en = 1'b0;
        check("t1_dout_zero", dout_bad - bad0, 32'd0);
        check("t1_color", {8'd0, bus_if.color}, {8'd0, 24'hB4B4B4});

        // Two words back to back: second word appears on dout
        push(1'b1, 1'b0, 1'b0, 24'h00FF00);
        push(1'b0, 1'b0, 1'b1, 24'h00FF00);
        send_range(24'h00FF00, 23, 0);
        bad0 = dout_bad;
        rise0 = dout_rises;
        dout_chk_en = 1'b1;
        send_range(24'h123456, 23, 0);
        dout_chk_en = 1'b0;
        hold(1'b0, 1400);
        check("t2_dout_follow", dout_bad - bad0, 32'd0);
        check("t2_dout_pulses", dout_rises - rise0, 32'd24);

        // Partial word: frame_end and err together, color held
        push(1'b0, 1'b1, 1'b1, 24'h00FF00);
        send_range(24'hF0F0F0, 23, 12);
        hold(1'b0, 1400);
        check("t3_color_held", {8'd0, bus_if.color}, {8'd0, 24'h00FF00});

        // Glitch between bits 5 and 6 is flagged and dropped
        push(1'b0, 1'b1, 1'b0, 24'h00FF00);
        push(1'b1, 1'b0, 1'b0, 24'hA5A5A5);
        push(1'b0, 1'b0, 1'b1, 24'hA5A5A5);
        send_range(24'hA5A5A5, 23, 19);
        hold(1'b1, 2);
        hold(1'b0, 20);
        send_range(24'hA5A5A5, 18, 0);
        hold(1'b0, 1400);

        // Overlong high; bits before the next reset gap are ignored
        push(1'b0, 1'b1, 1'b0, 24'hA5A5A5);
        send_range(24'hC3C3C3, 23, 16);
        hold(1'b1, 60);
        hold(1'b0, 31);
        send_range(24'hFFFFFF, 23, 20);
        hold(1'b0, 1400);
        push(1'b1, 1'b0, 1'b0, 24'h5A5A5A);
        push(1'b0, 1'b0, 1'b1, 24'h5A5A5A);
        send_range(24'h5A5A5A, 23, 0);
        hold(1'b0, 1400);

        // Reset mid-word clears everything at once
        send_range(24'h0F0F0F, 23, 14);
        rst_n = 1'b0;
        #1;
        check("t6_rst_color",     {8'd0, bus_if.color}, 32'd0);
        check("t6_rst_valid",     {31'd0, bus_if.valid}, 32'd0);
        check("t6_rst_frame_end", {31'd0, bus_if.frame_end}, 32'd0);
        check("t6_rst_err",       {31'd0, bus_if.err}, 32'd0);
        check("t6_rst_dout",      {31'd0, bus_if.dout}, 32'd0);
        hold(1'b0, 5);
        rst_n = 1'b1;
        hold(1'b0, 1400);
        push(1'b1, 1'b0, 1'b0, 24'h3C3C3C);
        push(1'b0, 1'b0, 1'b1, 24'h3C3C3C);
        send_range(24'h3C3C3C, 23, 0);
        hold(1'b0, 1400);

        check("events_outstanding", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Time limit on the whole run
    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
